// File: rtl/bootram_pkg.sv
// Shared constants and types for the parametrised boot RAM.
package bootram_pkg;

  localparam int RD_BYPASS  = 0;
  localparam int RD_PIPE    = 1;

  localparam int WR_NORMAL  = 0;
  localparam int WR_THROUGH = 1;
  localparam int WR_RBW     = 2;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  // Source of the word presented by the first read stage.
  typedef enum logic [1:0] {
    SRC_OLD,
    SRC_MERGE,
    SRC_ZERO
  } rd_src_t;

endpackage

// File: rtl/bootram_if.sv
// CPU-side access bus of the boot RAM: request, read data and clear control.
interface bootram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic                  ce;
  logic                  oce;
  logic                  wre;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     ad;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  dout_vld;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output ce, oce, wre, be, ad, din, clr_req,
    input  dout, dout_vld, busy
  );

  modport slave (
    input  ce, oce, wre, be, ad, din, clr_req,
    output dout, dout_vld, busy
  );
endinterface

// File: rtl/bootram_array.sv
// Inferred single-port memory core with byte-lane writes and read-first output register.
module bootram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/bootram_sp_param.sv
// Parametrised single-port boot RAM: byte-lane writes, bypass/pipelined read,
// three write modes and a clear sequencer. BOOTRAM_CLR_ON_RST_EN clears after reset.
module bootram_sp_param
  import bootram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int READ_MODE  = RD_BYPASS,
  parameter int WRITE_MODE = WR_NORMAL
) (
  input logic      clk,
  input logic      reset,
  bootram_if.slave bus
);
  localparam int                NB      = DATA_W / 8;
  localparam int                AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_W = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic              busy_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic              start_clr;

  logic              acc;
  logic              in_range;
  logic              arr_en;
  logic [NB-1:0]     arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              s0_vld;
  rd_src_t           s0_src;
  logic [DATA_W-1:0] s0_din;
  logic [NB-1:0]     s0_be;
  logic [DATA_W-1:0] s0_word;

  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_c;
  logic              vld_q;
  logic              vld_c;

`ifdef BOOTRAM_CLR_ON_RST_EN
  logic rst_clr_pend;

  always_ff @(posedge clk) begin
    if (reset)               rst_clr_pend <= 1'b1;
    else if (state == IDLE)  rst_clr_pend <= 1'b0;
  end

  assign start_clr = bus.clr_req || rst_clr_pend;
`else
  assign start_clr = bus.clr_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      clr_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_clr) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_AD) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc      = bus.ce && (state == IDLE) && !reset;
  assign in_range = {1'b0, bus.ad} < DEPTH_W;

  // Reset gates every array write so an aborted clear leaves the current word intact.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = '0;
    arr_addr  = bus.ad;
    arr_wdata = bus.din;
    if (!reset) begin
      if (state == CLEAR) begin
        arr_en    = 1'b1;
        arr_we    = '1;
        arr_addr  = clr_cnt;
        arr_wdata = '0;
      end else if (acc && in_range) begin
        arr_en = 1'b1;
        arr_we = bus.wre ? bus.be : '0;
      end
    end
  end

  bootram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld <= 1'b0;
      s0_src <= SRC_ZERO;
      s0_din <= '0;
      s0_be  <= '0;
    end else begin
      s0_vld <= 1'b0;
      if (acc) begin
        s0_din <= bus.din;
        s0_be  <= bus.be;
        if (!bus.wre) begin
          s0_vld <= 1'b1;
          s0_src <= in_range ? SRC_OLD : SRC_ZERO;
        end else if (in_range && (WRITE_MODE != WR_NORMAL)) begin
          s0_vld <= 1'b1;
          s0_src <= (WRITE_MODE == WR_THROUGH) ? SRC_MERGE : SRC_OLD;
        end
      end
    end
  end

  // The array is read-first, so the merged post-write word is rebuilt from the old word.
  always_comb begin
    s0_word = arr_rdata;
    unique case (s0_src)
      SRC_MERGE: begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (s0_be[i]) s0_word[8*i +: 8] = s0_din[8*i +: 8];
        end
      end
      SRC_ZERO: s0_word = '0;
      default:  s0_word = arr_rdata;
    endcase
  end

  // Bypass presents stage 1 directly and keeps dout_q as the hold copy.
  always_comb begin
    if (READ_MODE == RD_PIPE) begin
      dout_c = dout_q;
      vld_c  = vld_q;
    end else begin
      dout_c = s0_vld ? s0_word : dout_q;
      vld_c  = s0_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else if (READ_MODE == RD_PIPE) begin
      vld_q <= s0_vld && bus.oce;
      if (s0_vld && bus.oce) dout_q <= s0_word;
    end else begin
      dout_q <= dout_c;
      vld_q  <= s0_vld;
    end
  end

  assign bus.dout     = dout_c;
  assign bus.dout_vld = vld_c;
  assign bus.busy     = busy_q;

endmodule
